// File: rtl/synth_pkg.sv
// Shared definitions for the synth datapath: sequencer states and datapath widths.
package synth_pkg;

   localparam int unsigned FREQ_W       = 18;
   localparam int unsigned SIG_W        = 12;
   localparam int unsigned TICK_DIV_DEF = 50000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/square_seq_ctrl_tick_prescaler.sv
// Modulo-TICK_DIV cycle counter producing a one-cycle tick; restart realigns it to a phase start.
module tick_prescaler
   import synth_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart || cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/square_seq_ctrl.sv
// Note sequencer: plays a table of (freq, duration) steps into square_gen with optional gaps and looping.
module square_seq_ctrl
   import synth_pkg::*;
#(
   parameter int unsigned STEPS     = 8,
   parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
   parameter int unsigned DUR_W     = 10,
   parameter int unsigned GAP_TICKS = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(STEPS)-1:0] wr_addr,
   input  logic [FREQ_W-1:0]        wr_freq,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic [$clog2(STEPS):0]   num_steps,
   input  logic                     loop,
   input  logic                     start,
   input  logic                     stop,
   output logic [FREQ_W-1:0]        freq,
   output logic                     add,
   output logic                     busy,
   output logic [$clog2(STEPS)-1:0] step,
   output logic                     done
);

   localparam int unsigned AW = $clog2(STEPS);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] STEPS_L = LW'(STEPS);

   seq_state_t        state_q, state_d;
   logic [AW-1:0]     step_q, step_d;
   logic [LW-1:0]     len_q, len_d;
   logic [DUR_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [FREQ_W-1:0] freq_q, freq_d;
   logic              add_q, add_d;
   logic              done_q, done_d;

   logic [FREQ_W-1:0] tbl_freq_q [STEPS];
   logic [DUR_W-1:0]  tbl_dur_q  [STEPS];

   logic              tick, restart, tbl_we;
   logic [LW-1:0]     eff_len;
   logic              start_ok, last_step, play_end, gap_end, boundary, finish;
   logic [AW-1:0]     adv_step, nxt_step;
   logic [FREQ_W-1:0] load_freq;
   logic [DUR_W-1:0]  cur_dur, dur_m1;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .tick    (tick)
   );

   assign tbl_we    = wr_en && (state_q == IDLE);
   assign eff_len   = (num_steps > STEPS_L) ? STEPS_L : num_steps;
   assign start_ok  = (state_q == IDLE) && start && (eff_len != '0);
   assign last_step = ({1'b0, step_q} == (len_q - LW'(1)));
   assign adv_step  = last_step ? '0 : step_q + 1'b1;
   assign nxt_step  = (state_q == IDLE) ? '0 : adv_step;
   // A write landing on the same edge as start must be seen by the first PLAY load.
   assign load_freq = (tbl_we && wr_addr == nxt_step) ? wr_freq : tbl_freq_q[nxt_step];

   assign cur_dur   = tbl_dur_q[step_q];
   assign dur_m1    = (cur_dur == '0) ? '0 : cur_dur - 1'b1;
   assign play_end  = (state_q == PLAY) && tick && (tick_cnt_q == dur_m1);
   assign gap_end   = (state_q == GAP) && tick &&
                      (32'(tick_cnt_q) + 32'd1 == 32'(GAP_TICKS));
   assign boundary  = gap_end || (play_end && GAP_TICKS == 0);
   assign finish    = boundary && last_step && !loop;

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      len_d      = len_q;
      tick_cnt_d = tick_cnt_q;
      freq_d     = freq_q;
      add_d      = add_q;
      done_d     = 1'b0;
      restart    = 1'b0;

      if (state_q != IDLE && tick) tick_cnt_d = tick_cnt_q + 1'b1;

      if (play_end && GAP_TICKS != 0) begin
         state_d    = GAP;
         add_d      = 1'b0;
         tick_cnt_d = '0;
         restart    = 1'b1;
      end

      if (start_ok || (boundary && !finish)) begin
         state_d    = PLAY;
         step_d     = nxt_step;
         tick_cnt_d = '0;
         restart    = 1'b1;
         freq_d     = load_freq;
         add_d      = (load_freq != '0);
      end

      if (start_ok) len_d = eff_len;

      // stop overrides both a start and a step boundary in the same cycle.
      if (finish || stop) begin
         state_d = IDLE;
         step_d  = '0;
         freq_d  = '0;
         add_d   = 1'b0;
         done_d  = finish && !stop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         step_q     <= '0;
         len_q      <= '0;
         tick_cnt_q <= '0;
         freq_q     <= '0;
         add_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         len_q      <= len_d;
         tick_cnt_q <= tick_cnt_d;
         freq_q     <= freq_d;
         add_q      <= add_d;
         done_q     <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < STEPS; i++) begin
            tbl_freq_q[i] <= '0;
            tbl_dur_q[i]  <= '0;
         end
      end else if (tbl_we) begin
         tbl_freq_q[wr_addr] <= wr_freq;
         tbl_dur_q[wr_addr]  <= wr_dur;
      end
   end

   assign freq = freq_q;
   assign add  = add_q;
   assign busy = (state_q != IDLE);
   assign step = step_q;
   assign done = done_q;

endmodule

// File: tb/tb_square_seq_ctrl.sv
// Randomized and directed bench for square_seq_ctrl against an expected per-cycle output trace.
module tb_square_seq_ctrl;

   localparam int unsigned STEPS = 8;
   localparam int unsigned TD    = 4;
   localparam int unsigned DW    = 10;
   localparam int unsigned GT    = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [17:0] wr_freq = '0;
   logic [9:0]  wr_dur = '0;
   logic [3:0]  num_steps = '0;
   logic        loop = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [17:0] freq;
   logic        add, busy, done;
   logic [2:0]  step;

   logic [23:0] obs;
   assign obs = {busy, add, freq, step, done};

   int checks = 0;
   int errors = 0;
   int sh_f [STEPS];
   int sh_d [STEPS];
   logic [23:0] trace [$];

   always #5 clk = ~clk;

   square_seq_ctrl #(
      .STEPS     (STEPS),
      .TICK_DIV  (TD),
      .DUR_W     (DW),
      .GAP_TICKS (GT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_freq   (wr_freq),
      .wr_dur    (wr_dur),
      .num_steps (num_steps),
      .loop      (loop),
      .start     (start),
      .stop      (stop),
      .freq      (freq),
      .add       (add),
      .busy      (busy),
      .step      (step),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (busy,add,freq,step,done)", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pk(bit b, bit a, int f, int s, bit d);
      return {b, a, 18'(f), 3'(s), d};
   endfunction

   // Expected outputs one entry per cycle after the start edge.
   task automatic build(input int len, input int passes);
      trace.delete();
      for (int p = 0; p < passes; p++)
         for (int s = 0; s < len; s++) begin
            int f = sh_f[s];
            int d = (sh_d[s] == 0) ? 1 : sh_d[s];
            repeat (d * TD) trace.push_back(pk(1, f != 0, f, s, 0));
            repeat (GT * TD) trace.push_back(pk(1, 0, f, s, 0));
         end
      trace.push_back(pk(0, 0, 0, 0, 1));
      trace.push_back(pk(0, 0, 0, 0, 0));
   endtask

   task automatic write_entry(input int a, input int f, input int d);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(a); wr_freq = 18'(f); wr_dur = 10'(d);
      @(negedge clk);
      wr_en = 1'b0;
      sh_f[a] = f; sh_d[a] = d;
   endtask

   task automatic run_play(input string tag, input int ns, input int passes, input int stop_at,
                           input bit busy_wr, input bit wr_start, input int wf, input int wd);
      int len = (ns > STEPS) ? STEPS : ns;
      int per_pass;
      @(negedge clk);
      if (wr_start) begin
         wr_en = 1'b1; wr_addr = '0; wr_freq = 18'(wf); wr_dur = 10'(wd);
         sh_f[0] = wf; sh_d[0] = wd;
      end
      build(len, passes);
      per_pass  = (trace.size() - 2) / passes;
      num_steps = 4'(ns);
      loop      = (passes > 1);
      start     = 1'b1;
      for (int i = 0; i < trace.size(); i++) begin
         @(negedge clk);
         start = 1'b0; wr_en = 1'b0;
         check(tag, 32'(obs), 32'(trace[i]));
         if (passes > 1 && i == (passes - 1) * per_pass) loop = 1'b0;
         if (busy_wr && i == 2) begin
            wr_en = 1'b1; wr_addr = '0; wr_freq = 18'd12345; wr_dur = 10'd5;
         end
         if (i == stop_at) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            check({tag, "_stop"}, 32'(obs), 32'd0);
            break;
         end
      end
      wr_en = 1'b0; loop = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < STEPS; i++) begin sh_f[i] = 0; sh_d[i] = 0; end
      #1 rst_n = 1'b0;
      #5 check("reset", 32'(obs), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      check("reset_rel", 32'(obs), 32'd0);

      write_entry(0, 56818, 3);
      write_entry(1, 66000, 2);
      run_play("oneshot", 2, 1, -1, 0, 0, 0, 0);
      run_play("loop", 2, 2, -1, 0, 0, 0, 0);
      run_play("loop3", 2, 3, -1, 0, 0, 0, 0);
      run_play("stop", 2, 1, 4, 0, 0, 0, 0);

      @(negedge clk);
      num_steps = 4'd2; start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("startstop", 32'(obs), 32'd0);
      @(negedge clk);
      check("startstop2", 32'(obs), 32'd0);

      write_entry(0, 0, 2);
      write_entry(1, 56818, 0);
      run_play("rest_zero", 2, 1, -1, 0, 0, 0, 0);

      run_play("busywr", 2, 1, -1, 1, 0, 0, 0);
      run_play("readback", 2, 1, -1, 0, 0, 0, 0);

      @(negedge clk);
      num_steps = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ns0", 32'(obs), 32'd0);
      @(negedge clk);
      check("ns0b", 32'(obs), 32'd0);

      for (int a = 0; a < STEPS; a++) write_entry(a, $urandom_range(1, 262143), $urandom_range(0, 2));
      run_play("len12", 12, 1, -1, 0, 0, 0, 0);

      run_play("wrstart", 1, 1, -1, 0, 1, 777, 1);

      for (int r = 0; r < 8; r++) begin
         repeat ($urandom_range(1, 5)) begin
            int f = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 262143);
            write_entry($urandom_range(0, STEPS - 1), f, $urandom_range(0, 3));
         end
         run_play("rand", $urandom_range(1, 12), $urandom_range(1, 2),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1, 0, 0, 0, 0);
      end

      @(negedge clk);
      num_steps = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1 check("async_rst", 32'(obs), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < STEPS; i++) begin sh_f[i] = 0; sh_d[i] = 0; end
      run_play("postrst", 1, 1, -1, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
